panda_instr_mem: RTL and testbench
==================================

// Module: panda_instr_mem
// PURPOSE
// - Word-addressed instruction memory that serves the core's fetch port: it takes instr_addr and
//   returns instr_rdata combinationally, so the IF stage captures data in the same cycle as its pc.
// - Includes a byte-serial program loader (valid/ready) that fills the memory after reset.
// - Sits at top level between the boot/debug byte source and panda_if_stage.
// PARAMETERS
// - Depth     1024          number of 32-bit words; power of two, >= 4
// - BaseAddr  32'h0000_0000 byte address of word 0; word aligned
// - NopInstr  32'h0000_0013 word returned on any invalid fetch (addi x0,x0,0)
// PORTS
// - clk_i            in   1   clock
// - rst_ni           in   1   reset, asynchronous, active-low
// - instr_addr_i     in   32  fetch byte address from the IF stage
// - instr_rdata_o    out  32  fetched instruction (combinational)
// - instr_err_o      out  1   fetch was invalid; NopInstr returned (combinational)
// - load_start_i     in   1   pulse: start or restart a program load
// - load_valid_i     in   1   load_byte_i valid
// - load_ready_o     out  1   loader accepts a byte this cycle
// - load_byte_i      in   8   program byte, little-endian within each word
// - load_last_i      in   1   qualifies the final byte of the image
// - load_busy_o      out  1   state==LOAD
// - load_done_o      out  1   state==DONE (image fully written)
// - load_err_o       out  1   state==ERR (overflow)
// - load_word_cnt_o  out  $clog2(Depth)+1  words committed in the current load
// BEHAVIOUR
// - FSM states IDLE, LOAD, DONE, ERR; reset value IDLE.
// - Reset values: wptr=0, byte_idx=0, word buffer=0. Consequently load_ready_o=0, busy/done/err=0,
//   word_cnt=0. Memory array is NOT reset, and its contents survive rst_ni.
// - load_start_i in any state -> LOAD next cycle; wptr, byte_idx and buffer are cleared.
//   load_start_i has priority over a simultaneous handshake. ready=0 outside LOAD, so no byte is
//   taken in that cycle.
// - load_ready_o = (state==LOAD). A handshake is load_valid_i & load_ready_o.
// - On handshake with byte_idx<3 and !last: buf[8*byte_idx +: 8] <= byte; byte_idx++.
// - On handshake with byte_idx==3 or last:
//   - mem[wptr] <= {byte in lane byte_idx, buffered lower lanes, upper lanes zero-padded};
//   - wptr++, byte_idx=0, buf=0; commit is on that same clock edge (no extra cycle).
//   - If last: -> DONE, else stay in LOAD.
// - Overflow: a handshake while wptr==Depth discards the byte and goes to ERR. ERR exits only via
//   load_start_i or reset. Filling exactly Depth words with last on the final byte -> DONE, not ERR.
// - load_word_cnt_o = wptr; it holds its value in DONE and ERR.
// - Fetch: idx = (instr_addr_i - BaseAddr) >> 2. Valid iff all of:
//   - instr_addr_i >= BaseAddr;
//   - idx < Depth;
//   - instr_addr_i[1:0]==0;
//   - state != LOAD.
//   - Valid: rdata = mem[idx], err=0. Invalid: rdata = NopInstr, err=1.
// - Read during write: read is combinational from the array. A write lands at the clock edge, so
//   same-cycle fetch returns the old word (the fetch is NOP during LOAD in any case).
// - Reset mid-load: -> IDLE immediately. The partial buffered word is lost; words already committed
//   remain in memory.
// - Arithmetic: index compare uses 32-bit unsigned subtraction. Addresses below BaseAddr wrap high
//   and fail the idx<Depth check.
// STRUCTURE
// - panda_pkg: typedef enum logic [1:0] {IMEM_IDLE, IMEM_LOAD, IMEM_DONE, IMEM_ERR} imem_state_e;
//   localparam NOP_INSTR = 32'h0000_0013 (default for NopInstr).
// - One sub-module, panda_byte_packer: byte_idx counter and lane buffer; emits word_valid and word.
//   The top holds the FSM, wptr, array and fetch logic.
// TESTING
// - Load bytes 13 00 00 00 b3 00 10 00 (last on 8th) -> mem[0]=0x00000013, mem[1]=0x001000b3,
//   done=1, word_cnt=2; fetch 0x4 -> 0x001000b3, err=0.
// - Load 5 bytes ..,AA with last on the 5th -> mem[1]=0x000000AA, word_cnt=2, done=1.
// - Fetch 0x2 -> 0x00000013, err=1. Fetch BaseAddr+4*Depth -> NOP, err=1. Any fetch while
//   busy=1 -> NOP, err=1.
// - Depth=4: 17 bytes without last -> first 16 bytes committed, 17th dropped, err=1, ready=0.
//   A new load_start_i -> busy=1, word_cnt=0.
// - Assert rst_ni low after 6 bytes of a 2nd load -> IDLE, word_cnt=0. mem[0] holds the new word;
//   mem[1] holds the old image word.
// - load_start_i with valid=1 in the same cycle -> byte not accepted; the next byte lands in lane 0.

Source files
------------

// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared types and constants for the panda instruction memory
package panda_pkg;

  // Loader state: IDLE after reset, LOAD while taking bytes, DONE after the
  // last byte, ERR after a byte arrived with the array already full.
  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_LOAD = 2'd1,
    IMEM_DONE = 2'd2,
    IMEM_ERR  = 2'd3
  } imem_state_e;

  // addi x0,x0,0 - returned on any invalid fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/panda_byte_packer.sv
// rtl/panda_byte_packer.sv - assembles little-endian bytes into 32-bit words
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   i_clear         drop any partially assembled word, restart at lane 0
//   i_push          a byte is accepted this cycle
//   i_byte          byte value, placed in lane byte_idx
//   i_last          final byte of the image; forces the word out early
//   o_word_valid    a complete (or last, zero-padded) word is emitted this cycle
//   o_word          the word being emitted (valid with o_word_valid)
module panda_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_byte_idx;
  logic [31:0] r_buf;
  logic [4:0]  w_shift;

  // Lanes above byte_idx are always zero in r_buf, so OR-ing the new byte in
  // also provides the zero padding for a short final word.
  assign w_shift      = {r_byte_idx, 3'b000};
  assign o_word       = r_buf | ({24'h0, i_byte} << w_shift);
  assign o_word_valid = i_push & ((r_byte_idx == 2'd3) | i_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_idx <= 2'd0;
      r_buf      <= 32'h0;
    end else if (i_clear) begin
      r_byte_idx <= 2'd0;
      r_buf      <= 32'h0;
    end else if (i_push) begin
      if (o_word_valid) begin
        r_byte_idx <= 2'd0;
        r_buf      <= 32'h0;
      end else begin
        r_byte_idx <= r_byte_idx + 2'd1;
        r_buf      <= o_word;
      end
    end
  end

endmodule

// File: rtl/panda_instr_mem.sv
// rtl/panda_instr_mem.sv - instruction memory with combinational fetch and byte-serial loader
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (array is not reset)
//   instr_addr_i       fetch byte address
//   instr_rdata_o      fetched word, or NopInstr when the fetch is invalid
//   instr_err_o        fetch invalid (misaligned, out of range, or loader busy)
//   load_start_i       start/restart a load (wins over a same-cycle handshake)
//   load_valid_i       load_byte_i valid
//   load_ready_o       loader accepts a byte (state LOAD)
//   load_byte_i        image byte, little-endian within a word
//   load_last_i        final byte of the image
//   load_busy_o        state LOAD
//   load_done_o        state DONE
//   load_err_o         state ERR (overflow)
//   load_word_cnt_o    words committed by the current load
module panda_instr_mem
  import panda_pkg::*;
#(
  parameter int          Depth    = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter logic [31:0] NopInstr = NOP_INSTR
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              instr_addr_i,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     load_start_i,
  input  logic                     load_valid_i,
  output logic                     load_ready_o,
  input  logic [7:0]               load_byte_i,
  input  logic                     load_last_i,
  output logic                     load_busy_o,
  output logic                     load_done_o,
  output logic                     load_err_o,
  output logic [$clog2(Depth):0]   load_word_cnt_o
);

  localparam int          AW      = $clog2(Depth);
  localparam int          CW      = AW + 1;
  localparam logic [31:0] DEPTH_W = 32'(Depth);
  localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

  imem_state_e   r_state;
  imem_state_e   w_next_state;
  logic [CW-1:0] r_wptr;
  logic [31:0]   r_mem [Depth];

  logic          w_ready;
  logic          w_hs;
  logic          w_full;
  logic          w_push;
  logic          w_word_valid;
  logic [31:0]   w_word;

  assign w_ready = (r_state == IMEM_LOAD);
  assign w_hs    = load_valid_i & w_ready;
  assign w_full  = (r_wptr == FULL_CNT);
  // Bytes arriving once the array is full are dropped; a start pulse also
  // suppresses the handshake so the new load begins cleanly in lane 0.
  assign w_push  = w_hs & ~w_full & ~load_start_i;

  panda_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_clear      (load_start_i),
    .i_push       (w_push),
    .i_byte       (load_byte_i),
    .i_last       (load_last_i),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IMEM_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (load_start_i) begin
      w_next_state = IMEM_LOAD;
    end else if (r_state == IMEM_LOAD) begin
      if (w_hs && w_full) begin
        w_next_state = IMEM_ERR;
      end else if (w_word_valid && load_last_i) begin
        w_next_state = IMEM_DONE;
      end
    end
  end

  // Output logic
  always_comb begin
    load_ready_o = 1'b0;
    load_busy_o  = 1'b0;
    load_done_o  = 1'b0;
    load_err_o   = 1'b0;
    case (r_state)
      IMEM_LOAD: begin
        load_ready_o = 1'b1;
        load_busy_o  = 1'b1;
      end
      IMEM_DONE: load_done_o = 1'b1;
      IMEM_ERR:  load_err_o  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
    end else if (load_start_i) begin
      r_wptr <= '0;
    end else if (w_word_valid) begin
      r_wptr <= r_wptr + 1'b1;
    end
  end

  assign load_word_cnt_o = r_wptr;

  // Array has no reset so an image survives rst_ni. w_word_valid implies the
  // array is not full, so r_wptr is a legal index here.
  always_ff @(posedge clk_i) begin
    if (w_word_valid) begin
      r_mem[r_wptr[AW-1:0]] <= w_word;
    end
  end

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_fetch_ok;

  // Addresses below BaseAddr wrap to a huge offset and fail the range test.
  assign w_off      = instr_addr_i - BaseAddr;
  assign w_idx      = w_off[AW+1:2];
  assign w_fetch_ok = (instr_addr_i >= BaseAddr) && ((w_off >> 2) < DEPTH_W) &&
                      (instr_addr_i[1:0] == 2'b00) && (r_state != IMEM_LOAD);

  assign instr_rdata_o = w_fetch_ok ? r_mem[w_idx] : NopInstr;
  assign instr_err_o   = ~w_fetch_ok;

endmodule

// File: tb/tb_panda_instr_mem.sv
// tb/tb_panda_instr_mem.sv - directed self-checking bench for panda_instr_mem
module tb_panda_instr_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        start;
  logic        valid;
  logic [7:0]  lbyte;
  logic        last;
  logic        sel4;

  logic [31:0] rdata, rdata4;
  logic        ferr, ferr4;
  logic        ready, ready4;
  logic        busy, busy4;
  logic        done, done4;
  logic        lerr, lerr4;
  logic [10:0] cnt;
  logic [2:0]  cnt4;

  int checks;
  int errors;

  panda_instr_mem #(.Depth(1024)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .instr_addr_i    (addr),
    .instr_rdata_o   (rdata),
    .instr_err_o     (ferr),
    .load_start_i    (start & ~sel4),
    .load_valid_i    (valid & ~sel4),
    .load_ready_o    (ready),
    .load_byte_i     (lbyte),
    .load_last_i     (last),
    .load_busy_o     (busy),
    .load_done_o     (done),
    .load_err_o      (lerr),
    .load_word_cnt_o (cnt)
  );

  panda_instr_mem #(.Depth(4)) dut4 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .instr_addr_i    (addr),
    .instr_rdata_o   (rdata4),
    .instr_err_o     (ferr4),
    .load_start_i    (start & sel4),
    .load_valid_i    (valid & sel4),
    .load_ready_o    (ready4),
    .load_byte_i     (lbyte),
    .load_last_i     (last),
    .load_busy_o     (busy4),
    .load_done_o     (done4),
    .load_err_o      (lerr4),
    .load_word_cnt_o (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    @(negedge clk);
    valid = 1'b1;
    lbyte = b;
    last  = l;
    @(posedge clk);
    #1;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    @(negedge clk);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready, busy, done, lerr} !== 4'b0000 || cnt !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: rdy/busy/done/err=%b cnt=%0d, want 0000 cnt=0",
               {ready, busy, done, lerr}, cnt);
    end
    checks++;
    if ({ready4, busy4, done4, lerr4} !== 4'b0000 || cnt4 !== 3'd0) begin
      errors++;
      $display("FAIL reset_state4: rdy/busy/done/err=%b cnt=%0d, want 0000 cnt=0",
               {ready4, busy4, done4, lerr4}, cnt4);
    end
  endtask

  task automatic test_load_basic();
    logic [7:0] img [8];
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hb3, 8'h00, 8'h10, 8'h00};
    sel4 = 1'b0;
    start_load();
    checks++;
    if (busy !== 1'b1 || ready !== 1'b1 || cnt !== 11'd0) begin
      errors++;
      $display("FAIL load_busy: busy=%b ready=%b cnt=%0d, want 1 1 0", busy, ready, cnt);
    end
    fetch(32'h0);
    checks++;
    if (rdata !== 32'h0000_0013 || ferr !== 1'b1) begin
      errors++;
      $display("FAIL fetch_while_busy: rdata=%h err=%b, want 00000013 1", rdata, ferr);
    end
    for (int i = 0; i < 8; i++) send(img[i], i == 7);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== 11'd2) begin
      errors++;
      $display("FAIL load_done: done=%b busy=%b cnt=%0d, want 1 0 2", done, busy, cnt);
    end
    fetch(32'h0);
    checks++;
    if (rdata !== 32'h0000_0013 || ferr !== 1'b0) begin
      errors++;
      $display("FAIL fetch_w0: rdata=%h err=%b, want 00000013 0", rdata, ferr);
    end
    fetch(32'h4);
    checks++;
    if (rdata !== 32'h0010_00b3 || ferr !== 1'b0) begin
      errors++;
      $display("FAIL fetch_w1: rdata=%h err=%b, want 001000b3 0", rdata, ferr);
    end
  endtask

  task automatic test_fetch_invalid();
    fetch(32'h2);
    checks++;
    if (rdata !== 32'h0000_0013 || ferr !== 1'b1) begin
      errors++;
      $display("FAIL fetch_misaligned: rdata=%h err=%b, want 00000013 1", rdata, ferr);
    end
    fetch(32'h0000_1000);
    checks++;
    if (rdata !== 32'h0000_0013 || ferr !== 1'b1) begin
      errors++;
      $display("FAIL fetch_past_end: rdata=%h err=%b, want 00000013 1", rdata, ferr);
    end
    fetch(32'h0000_0FFC);
    checks++;
    if (ferr !== 1'b0) begin
      errors++;
      $display("FAIL fetch_last_word: err=%b, want 0", ferr);
    end
    fetch(32'hFFFF_FFFC);
    checks++;
    if (rdata !== 32'h0000_0013 || ferr !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wrap: rdata=%h err=%b, want 00000013 1", rdata, ferr);
    end
  endtask

  task automatic test_partial_last();
    logic [7:0] img [5];
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    sel4 = 1'b0;
    start_load();
    for (int i = 0; i < 5; i++) send(img[i], i == 4);
    checks++;
    if (done !== 1'b1 || cnt !== 11'd2) begin
      errors++;
      $display("FAIL partial_done: done=%b cnt=%0d, want 1 2", done, cnt);
    end
    fetch(32'h0);
    checks++;
    if (rdata !== 32'h0403_0201 || ferr !== 1'b0) begin
      errors++;
      $display("FAIL partial_w0: rdata=%h err=%b, want 04030201 0", rdata, ferr);
    end
    fetch(32'h4);
    checks++;
    if (rdata !== 32'h0000_00AA || ferr !== 1'b0) begin
      errors++;
      $display("FAIL partial_w1: rdata=%h err=%b, want 000000aa 0", rdata, ferr);
    end
  endtask

  task automatic test_start_priority();
    logic [7:0] img [4];
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel4 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    valid = 1'b1;
    lbyte = 8'h55;
    @(posedge clk);
    #1;
    start = 1'b0;
    valid = 1'b0;
    for (int i = 0; i < 4; i++) send(img[i], i == 3);
    checks++;
    if (done !== 1'b1 || cnt !== 11'd1) begin
      errors++;
      $display("FAIL start_prio_cnt: done=%b cnt=%0d, want 1 1", done, cnt);
    end
    fetch(32'h0);
    checks++;
    if (rdata !== 32'h4433_2211) begin
      errors++;
      $display("FAIL start_prio_word: rdata=%h, want 44332211", rdata);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] img [8];
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hb3, 8'h00, 8'h10, 8'h00};
    sel4 = 1'b0;
    start_load();
    for (int i = 0; i < 8; i++) send(img[i], i == 7);
    start_load();
    for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt !== 11'd0) begin
      errors++;
      $display("FAIL midload_reset: busy=%b done=%b cnt=%0d, want 0 0 0", busy, done, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h0);
    checks++;
    if (rdata !== 32'h4433_2211 || ferr !== 1'b0) begin
      errors++;
      $display("FAIL midload_w0: rdata=%h err=%b, want 44332211 0", rdata, ferr);
    end
    fetch(32'h4);
    checks++;
    if (rdata !== 32'h0010_00b3) begin
      errors++;
      $display("FAIL midload_w1: rdata=%h, want 001000b3", rdata);
    end
  endtask

  task automatic test_overflow();
    sel4 = 1'b1;
    start_load();
    for (int i = 0; i < 16; i++) send(8'(i + 1), 1'b0);
    checks++;
    if (busy4 !== 1'b1 || cnt4 !== 3'd4 || lerr4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: busy=%b cnt=%0d err=%b, want 1 4 0", busy4, cnt4, lerr4);
    end
    send(8'hEE, 1'b0);
    checks++;
    if (lerr4 !== 1'b1 || ready4 !== 1'b0 || cnt4 !== 3'd4) begin
      errors++;
      $display("FAIL ovf_err: err=%b ready=%b cnt=%0d, want 1 0 4", lerr4, ready4, cnt4);
    end
    fetch(32'h0);
    checks++;
    if (rdata4 !== 32'h0403_0201 || ferr4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_w0: rdata=%h err=%b, want 04030201 0", rdata4, ferr4);
    end
    fetch(32'hC);
    checks++;
    if (rdata4 !== 32'h100F_0E0D || ferr4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_w3: rdata=%h err=%b, want 100f0e0d 0", rdata4, ferr4);
    end
    fetch(32'h10);
    checks++;
    if (rdata4 !== 32'h0000_0013 || ferr4 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_range: rdata=%h err=%b, want 00000013 1", rdata4, ferr4);
    end
    start_load();
    checks++;
    if (busy4 !== 1'b1 || cnt4 !== 3'd0 || lerr4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_restart: busy=%b cnt=%0d err=%b, want 1 0 0", busy4, cnt4, lerr4);
    end
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), i == 15);
    checks++;
    if (done4 !== 1'b1 || lerr4 !== 1'b0 || cnt4 !== 3'd4) begin
      errors++;
      $display("FAIL exact_fill: done=%b err=%b cnt=%0d, want 1 0 4", done4, lerr4, cnt4);
    end
    fetch(32'hC);
    checks++;
    if (rdata4 !== 32'h2F2E_2D2C) begin
      errors++;
      $display("FAIL exact_fill_w3: rdata=%h, want 2f2e2d2c", rdata4);
    end
    sel4 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    addr   = 32'h0;
    start  = 1'b0;
    valid  = 1'b0;
    lbyte  = 8'h0;
    last   = 1'b0;
    sel4   = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_load_basic();
    test_fetch_invalid();
    test_partial_last();
    test_start_priority();
    test_reset_midload();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
